// File: rtl/mux_nway_arb_pkg.sv
// mux_nway_arb_pkg: shared mode encodings for the n-way arbitrated mux
package mux_nway_arb_pkg;
  localparam logic MUX_MODE_FIXED = 1'b0;
  localparam logic MUX_MODE_RR    = 1'b1;
endpackage

// File: rtl/mux_nway_arb_rr_pick.sv
// rr_pick: rotating priority encoder, first set req at or after start (mod N)
module rr_pick
  import mux_nway_arb_pkg::*;
#(
  parameter int N = 4,
  localparam int SW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [SW-1:0] start,
  output logic [SW-1:0] gnt_idx,
  output logic          gnt_vld
);
  // scan from farthest to nearest so the nearest request wins
  always_comb begin
    gnt_idx = '0;
    gnt_vld = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      int j;
      j = int'(start) + k;
      j = (j >= N) ? j - N : j;
      if (req[j]) begin
        gnt_idx = SW'(j);
        gnt_vld = 1'b1;
      end
    end
  end
endmodule

// File: rtl/mux_nway_arb.sv
// mux_nway_arb: n-way valid/ready mux with fixed or round-robin select and registered output
module mux_nway_arb
  import mux_nway_arb_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHANNELS = 4,
  localparam int SEL_W = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          sel,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_W-1:0]          out_chan,
  output logic                      out_valid,
  input  logic                      out_ready
);
  logic [SEL_W-1:0] ptr, rr_idx, grant;
  logic             rr_vld, fix_vld, gnt_vld, load_en;
  logic [WIDTH-1:0] pick;

  rr_pick #(.N(CHANNELS)) u_pick (
    .req(in_valid),
    .start(ptr),
    .gnt_idx(rr_idx),
    .gnt_vld(rr_vld)
  );

  // out-of-range sel shifts past the top bit, so it can never grant
  assign fix_vld = |(in_valid & (CHANNELS'(1) << sel));
  assign grant   = (mode == MUX_MODE_RR) ? rr_idx : sel;
  assign gnt_vld = (mode == MUX_MODE_RR) ? rr_vld : fix_vld;
  assign load_en = !out_valid | out_ready;
  assign in_ready = (!reset && load_en && gnt_vld) ? (CHANNELS'(1) << grant) : '0;

  // select the granted channel's word
  always_comb begin
    pick = '0;
    for (int c = 0; c < CHANNELS; c++)
      if (grant == SEL_W'(c)) pick = in_data[c*WIDTH +: WIDTH];
  end

  // output stage and round-robin pointer
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= '0;
      ptr       <= '0;
    end else if (load_en) begin
      out_valid <= gnt_vld;
      if (gnt_vld) begin
        out_data <= pick;
        out_chan <= grant;
        if (mode == MUX_MODE_RR)
          ptr <= (grant == SEL_W'(CHANNELS - 1)) ? '0 : grant + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_mux_nway_arb.sv
// tb_mux_nway_arb: randomized and directed checks of mux_nway_arb against a queue-free reference model
module tb_mux_nway_arb;
  import mux_nway_arb_pkg::*;
  logic        clk = 0;
  logic        reset, mode, out_ready, out_valid;
  logic [1:0]  sel, out_chan;
  logic [63:0] in_data;
  logic [3:0]  in_valid, in_ready;
  logic [15:0] out_data;
  logic        reset3, mode3, out_ready3, out_valid3;
  logic [1:0]  sel3, out_chan3;
  logic [47:0] in_data3;
  logic [2:0]  in_valid3, in_ready3;
  logic [15:0] out_data3;
  int total = 0, bad = 0;
  bit          m_valid;
  logic [15:0] m_data;
  int          m_chan, m_ptr;

  always #5 clk = ~clk;

  mux_nway_arb #(.WIDTH(16), .CHANNELS(4)) dut (
    .clk(clk), .reset(reset), .mode(mode), .sel(sel), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
    .out_chan(out_chan), .out_valid(out_valid), .out_ready(out_ready)
  );

  mux_nway_arb #(.WIDTH(16), .CHANNELS(3)) dut3 (
    .clk(clk), .reset(reset3), .mode(mode3), .sel(sel3), .in_data(in_data3),
    .in_valid(in_valid3), .in_ready(in_ready3), .out_data(out_data3),
    .out_chan(out_chan3), .out_valid(out_valid3), .out_ready(out_ready3)
  );

  function automatic int ref_grant();
    if (mode == MUX_MODE_FIXED) return (in_valid[sel]) ? int'(sel) : -1;
    for (int k = 0; k < 4; k++)
      if (in_valid[(m_ptr + k) % 4]) return (m_ptr + k) % 4;
    return -1;
  endfunction

  function automatic logic [3:0] ref_ready();
    int g;
    g = ref_grant();
    return (!reset && (!m_valid || out_ready) && g >= 0) ? 4'(1 << g) : 4'b0;
  endfunction

  task automatic tick();
    int g;
    g = ref_grant();
    if (reset) begin
      m_valid = 0; m_data = 0; m_chan = 0; m_ptr = 0;
    end else if (!m_valid || out_ready) begin
      m_valid = (g >= 0);
      if (g >= 0) begin
        m_data = in_data[g*16 +: 16];
        m_chan = g;
        if (mode == MUX_MODE_RR) m_ptr = (g + 1) % 4;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1; mode = MUX_MODE_RR; sel = 0; in_valid = 4'hF; out_ready = 1;
    in_data = {16'h1111, 16'h2222, 16'h3333, 16'h4444};
    #1;
    total++;
    if (in_ready !== 4'b0000) begin bad++; $display("FAIL reset_ready got=%b exp=0000", in_ready); end
    tick(); tick();
    total++;
    if (out_valid !== 1'b0 || out_data !== 16'h0 || out_chan !== 2'd0) begin
      bad++; $display("FAIL reset_out got v=%b d=%h c=%0d exp 0/0000/0", out_valid, out_data, out_chan);
    end
    total++;
    if (in_ready !== 4'b0000) begin bad++; $display("FAIL reset_ready2 got=%b exp=0000", in_ready); end
    reset = 0;
  endtask

  task automatic test_fixed();
    mode = MUX_MODE_FIXED; sel = 2; out_ready = 1; in_valid = 4'b0100;
    in_data = {16'hDEAD, 16'h1234, 16'hBEEF, 16'hCAFE};
    #1;
    total++;
    if (in_ready !== 4'b0100) begin bad++; $display("FAIL fixed_ready got=%b exp=0100", in_ready); end
    tick();
    total++;
    if (out_valid !== 1 || out_data !== 16'h1234 || out_chan !== 2'd2) begin
      bad++; $display("FAIL fixed_out got v=%b d=%h c=%0d exp 1/1234/2", out_valid, out_data, out_chan);
    end
    in_valid = 4'b1011;
    #1;
    total++;
    if (in_ready !== 4'b0000) begin bad++; $display("FAIL fixed_noreq got=%b exp=0000", in_ready); end
    tick();
    total++;
    if (out_valid !== 0 || out_data !== 16'h1234) begin
      bad++; $display("FAIL fixed_drain got v=%b d=%h exp 0/1234", out_valid, out_data);
    end
  endtask

  task automatic test_round_robin();
    int exp_a[5] = '{0, 1, 2, 3, 0};
    int exp_b[4] = '{1, 3, 1, 3};
    mode = MUX_MODE_RR; out_ready = 1; in_valid = 4'hF;
    in_data = {16'h0000, 16'h9876, 16'h5555, 16'hAAAA};
    for (int i = 0; i < 5; i++) begin
      tick();
      total++;
      if (out_valid !== 1 || int'(out_chan) !== exp_a[i] || out_data !== in_data[exp_a[i]*16 +: 16]) begin
        bad++; $display("FAIL rr_all[%0d] got c=%0d d=%h exp c=%0d", i, out_chan, out_data, exp_a[i]);
      end
    end
    in_valid = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      tick();
      total++;
      if (out_valid !== 1 || int'(out_chan) !== exp_b[i]) begin
        bad++; $display("FAIL rr_pair[%0d] got c=%0d exp c=%0d", i, out_chan, exp_b[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    mode = MUX_MODE_FIXED; sel = 1; in_valid = 4'b0010; out_ready = 1;
    in_data = {16'h0000, 16'h9876, 16'h5555, 16'hAAAA};
    tick();
    out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      in_data = {$urandom, $urandom};
      in_valid = 4'($urandom);
      sel = 2'($urandom);
      mode = 1'($urandom);
      #1;
      total++;
      if (in_ready !== 4'b0000) begin bad++; $display("FAIL stall_ready[%0d] got=%b exp=0000", i, in_ready); end
      tick();
      total++;
      if (out_valid !== 1 || out_data !== 16'h5555 || out_chan !== 2'd1) begin
        bad++; $display("FAIL stall_hold[%0d] got v=%b d=%h c=%0d exp 1/5555/1", i, out_valid, out_data, out_chan);
      end
    end
    mode = MUX_MODE_FIXED; sel = 2; in_valid = 4'b0100; in_data[47:32] = 16'h7E57; out_ready = 1;
    #1;
    total++;
    if (in_ready !== 4'b0100) begin bad++; $display("FAIL release_ready got=%b exp=0100", in_ready); end
    tick();
    total++;
    if (out_valid !== 1 || out_data !== 16'h7E57 || out_chan !== 2'd2) begin
      bad++; $display("FAIL release_load got v=%b d=%h c=%0d exp 1/7e57/2", out_valid, out_data, out_chan);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      reset = ($urandom_range(0, 49) == 0);
      mode = 1'($urandom);
      sel = 2'($urandom);
      in_valid = 4'($urandom);
      in_data = {$urandom, $urandom};
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      total++;
      if (in_ready !== ref_ready()) begin
        bad++; $display("FAIL rand_ready[%0d] got=%b exp=%b", i, in_ready, ref_ready());
      end
      tick();
      total++;
      if (out_valid !== m_valid || out_data !== m_data || int'(out_chan) !== m_chan) begin
        bad++; $display("FAIL rand_out[%0d] got v=%b d=%h c=%0d exp v=%b d=%h c=%0d",
                        i, out_valid, out_data, out_chan, m_valid, m_data, m_chan);
      end
    end
    reset = 0;
  endtask

  task automatic test_reset_mid();
    mode = MUX_MODE_RR; out_ready = 1; in_valid = 4'b0100;
    tick();
    total++;
    if (out_chan !== 2'd2 || out_valid !== 1) begin bad++; $display("FAIL mid_setup got c=%0d v=%b exp 2/1", out_chan, out_valid); end
    out_ready = 0;
    tick();
    reset = 1;
    tick();
    total++;
    if (out_valid !== 0 || out_data !== 16'h0) begin
      bad++; $display("FAIL mid_reset got v=%b d=%h exp 0/0000", out_valid, out_data);
    end
    reset = 0; out_ready = 1; in_valid = 4'b1100;
    #1;
    total++;
    if (in_ready !== 4'b0100) begin bad++; $display("FAIL mid_first got=%b exp=0100", in_ready); end
    tick();
    total++;
    if (out_chan !== 2'd2 || out_valid !== 1) begin bad++; $display("FAIL mid_chan got c=%0d v=%b exp 2/1", out_chan, out_valid); end
  endtask

  task automatic test_wrap3();
    reset3 = 1; mode3 = MUX_MODE_RR; sel3 = 0; out_ready3 = 1; in_valid3 = 3'b000;
    in_data3 = {16'hC2C2, 16'hB1B1, 16'hA0A0};
    @(posedge clk); #1;
    reset3 = 0; in_valid3 = 3'b010;
    @(posedge clk); #1;
    total++;
    if (out_chan3 !== 2'd1 || out_valid3 !== 1) begin bad++; $display("FAIL wrap_setup got c=%0d exp 1", out_chan3); end
    in_valid3 = 3'b001;
    #1;
    total++;
    if (in_ready3 !== 3'b001) begin bad++; $display("FAIL wrap_ready got=%b exp=001", in_ready3); end
    @(posedge clk); #1;
    total++;
    if (out_chan3 !== 2'd0 || out_data3 !== 16'hA0A0) begin
      bad++; $display("FAIL wrap_grant got c=%0d d=%h exp 0/a0a0", out_chan3, out_data3);
    end
    in_valid3 = 3'b111;
    #1;
    total++;
    if (in_ready3 !== 3'b010) begin bad++; $display("FAIL wrap_ptr got=%b exp=010", in_ready3); end
    mode3 = MUX_MODE_FIXED; sel3 = 2'd3;
    #1;
    total++;
    if (in_ready3 !== 3'b000) begin bad++; $display("FAIL sel_oob_ready got=%b exp=000", in_ready3); end
    @(posedge clk); #1;
    total++;
    if (out_valid3 !== 0) begin bad++; $display("FAIL sel_oob_out got v=%b exp 0", out_valid3); end
  endtask

  initial begin
    reset3 = 1; mode3 = 0; sel3 = 0; out_ready3 = 1; in_valid3 = 0; in_data3 = 0;
    m_valid = 0; m_data = 0; m_chan = 0; m_ptr = 0;
    #1;
    test_reset();
    test_fixed();
    test_round_robin();
    test_backpressure();
    test_random();
    test_reset_mid();
    test_wrap3();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
